// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the instruction-fetch
// port (I) and the data port (D). One transaction is in flight at a time, and
// each one steps through ISSUE -> WAIT -> RESP. D has fixed priority, but an
// anti-starvation counter forces an I grant after STARVE_MAX consecutive D
// grants taken while I was waiting. Every output comes straight from a register.
module mips_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          reset,
    // instruction fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_bw,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    // memory macro side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_bw,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Transaction owner encoding
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Instruction fetches are always full words
    localparam logic [1:0] BW_WORD = 2'b10;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    // Control state
    logic [1:0]    state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [7:0]    tmo_q, tmo_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;

    // Registered outputs
    logic          i_gnt_q, i_gnt_d;
    logic          d_gnt_q, d_gnt_d;
    logic          i_rvalid_q, i_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic          err_q, err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    mem_bw_q, mem_bw_d;

    // Completion bookkeeping shared by the normal and the timeout exit of WAIT
    logic          finish;
    logic          finish_err;
    logic [DW-1:0] finish_data;

    // Arbitration decision (only consumed in IDLE)
    logic          pick_i;

    // I wins when it is alone, or when D has starved it for STARVE_MAX grants
    always_comb begin
        pick_i = i_req && (!d_req || (starve_q == STARVE_LIM));
    end

    // Next-state and next-output logic for the whole transaction sequencer
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        owner_d     = owner_q;
        we_d        = we_q;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        err_d       = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_bw_d    = mem_bw_q;
        finish      = 1'b0;
        finish_err  = 1'b0;
        finish_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // Grant and memory strobe are both launched from this edge
                    // so that they appear together during ISSUE.
                    state_d  = ST_ISSUE;
                    mem_en_d = 1'b1;
                    if (pick_i) begin
                        owner_d    = OWN_I;
                        we_d       = 1'b0;
                        i_gnt_d    = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                        mem_bw_d   = BW_WORD;
                        starve_d   = '0;
                    end else begin
                        owner_d     = OWN_D;
                        we_d        = d_we;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_bw_d    = d_bw;
                        if (!i_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end

            ST_WAIT: begin
                if (mem_rvalid) begin
                    finish      = 1'b1;
                    finish_data = mem_rdata;
                end else if (tmo_q == TMO_LAST) begin
                    // Memory never answered: complete with an error and zero data
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response pulse and data capture land in RESP, routed to the owner
        if (finish) begin
            state_d = ST_RESP;
            err_d   = finish_err;
            if (owner_q == OWN_I) begin
                i_rvalid_d = 1'b1;
                i_rdata_d  = finish_data;
            end else begin
                d_rvalid_d = 1'b1;
                // A write ack carries no data, so d_rdata keeps the last read
                if (!we_q) begin
                    d_rdata_d = finish_data;
                end
            end
        end
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            owner_q     <= OWN_I;
            we_q        <= 1'b0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bw_q    <= BW_WORD;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            err_q       <= err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bw_q    <= mem_bw_d;
        end
    end

    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign err       = err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_bw    = mem_bw_q;

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port (I) and the data-access port (D).
- Sequences every access as issue → wait → respond, with one transaction outstanding.
- Arbitrates with fixed D-priority plus an anti-starvation counter for I.
- Sits between the instruction-fetch unit, the data-memory interface and the memory macro; the CPU stalls on a missing grant or rvalid.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive D grants allowed while I waits before I is forced to win (1..15).
- TIMEOUT, 16, WAIT cycles without mem_rvalid before an error completion (2..255).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  one-cycle pulse, I request accepted
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DW  fetched word
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_bw  in  2  byte width: 00 byte, 01 half, 10 word
- d_gnt  out  1  one-cycle pulse, D request accepted
- d_rvalid  out  1  one-cycle pulse, read data valid or write ack
- d_rdata  out  DW  read data
- err  out  1  one-cycle pulse with x_rvalid on timeout
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_bw  out  2  byte width (I accesses drive 10)
- mem_rvalid  in  1  completion from memory (read data or write ack), latency ≥1 cycle after mem_en
- mem_rdata  in  DW  read data, valid with mem_rvalid

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE; starve_cnt 0; tmo_cnt 0.
  - All pulses 0; mem_en 0; mem_we 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata: 0; mem_bw 10.
- Reset mid-transaction returns to IDLE next cycle. No rvalid is issued for the aborted access, and a late mem_rvalid is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If i_req or d_req is high at a clock edge, select a winner, latch owner and request fields, and go to ISSUE.
  - A request dropped before its grant is discarded silently.
- Arbitration (evaluated in IDLE only):
  - D only → D. I only → I.
  - Both → D, unless starve_cnt == STARVE_MAX, in which case I wins.
- starve_cnt rules:
  - +1 on a D grant while i_req is high.
  - Reset to 0 on an I grant, or on a D grant while i_req is low.
  - Saturates at STARVE_MAX.
- ISSUE (exactly 1 cycle):
  - mem_en = 1 with the latched fields; mem_we = d_we for D, 0 for I.
  - Owner's x_gnt = 1 in this same cycle; the requester may change fields from the next cycle.
  - Next state: WAIT; tmo_cnt cleared.
- WAIT:
  - On mem_rvalid: capture mem_rdata into the owner's rdata register, go to RESP.
  - Otherwise tmo_cnt +1. When tmo_cnt reaches TIMEOUT-1 without mem_rvalid: go to RESP with error flag set and rdata forced to 0.
  - mem_rvalid in any other state is ignored.
- RESP (1 cycle):
  - Owner's x_rvalid = 1; err = error flag. The non-owner rvalid stays 0.
  - For D writes, d_rdata holds its previous value.
  - Next state: IDLE.
- Latency:
  - Request seen at edge N → gnt/mem_en in cycle N+1 → mem_rvalid at N+1+L → x_rvalid one cycle later.
  - Back-to-back issue spacing is L+3 cycles.
- x_rdata holds its value until the next RESP for that port.
- Simultaneous events:
  - A new req arriving during ISSUE, WAIT or RESP waits for IDLE; it is never granted early and never dropped while held.
  - At most one gnt and one rvalid are high in any cycle.

Test Plan:
- Reset, then I read addr 0x0000_0040 with memory L=1 returning 0x2402_0005 → i_gnt cycle 1, mem_en=1/mem_we=0/mem_bw=10, i_rvalid cycle 3 with i_rdata=0x2402_0005, err=0.
- i_req and d_req (write 0x1000, data 0xDEAD_BEEF, bw=10) both raised in the same cycle → D granted first with mem_we=1 and mem_wdata=0xDEAD_BEEF; d_rvalid, then I granted.
- d_req held continuously with i_req held, STARVE_MAX=4 → grant order D,D,D,D,I,D,…; starve_cnt returns to 0 after the I grant.
- Memory never asserts mem_rvalid (TIMEOUT=16) on a D read → d_rvalid=1, err=1, d_rdata=0 exactly 17 cycles after d_gnt; FSM back in IDLE; a following I read completes normally.
- Reset asserted during WAIT, then mem_rvalid arriving 2 cycles later → no rvalid pulse, all outputs at reset values, next request granted normally.
- Memory L=3, D byte read bw=00 at 0x2003 → mem_bw=00; d_rvalid exactly 4 cycles after d_gnt; no second mem_en during WAIT.
